// File: rtl/keypad_time_entry_if.sv
// Keypad entry bus: raw keypad/encoder inputs and control from the controller,
// MM:SS BCD entry buffer and status back to the cook-timer load path.
interface keypad_time_entry_if;
  logic [9:0] keypad;
  logic [3:0] digit;
  logic       entry_enable;
  logic       clear;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [2:0] digit_count;
  logic       entry_full;
  logic       time_valid;
  logic       key_accepted;

  modport master (
    output keypad, digit, entry_enable, clear,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  digit_count, entry_full, time_valid, key_accepted
  );

  modport slave (
    input  keypad, digit, entry_enable, clear,
    output min_tens, min_ones, sec_tens, sec_ones,
    output digit_count, entry_full, time_valid, key_accepted
  );
endinterface

// File: rtl/keypad_time_entry.sv
// Debounces the raw keypad, captures one digit per physical press and shifts
// accepted digits into a 4-digit BCD MM:SS entry buffer.
module keypad_time_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_time_entry_if.slave  kp_if
);

  localparam logic [7:0] LP_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    WAIT_RELEASE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [9:0] r_pattern, w_pattern_nxt;
  logic       w_valid;
  logic       w_capture;
  logic       w_shift;

  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [2:0] r_count;
  logic       r_accepted;

  // Exactly one line asserted: nonzero and clearing the lowest set bit leaves zero.
  assign w_valid = (kp_if.keypad != '0) &&
                   ((kp_if.keypad & (kp_if.keypad - 10'd1)) == '0);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pattern <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pattern <= w_pattern_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pattern_nxt = r_pattern;
    w_capture     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_pattern_nxt = kp_if.keypad;
          w_cnt_nxt     = '0;
          w_state_nxt   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (kp_if.keypad == r_pattern) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_capture   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = WAIT_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      WAIT_RELEASE: begin
        // Any nonzero keypad restarts the release window; a held key never recaptures.
        if (kp_if.keypad == '0) begin
          if (r_cnt == LP_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Leading zeros are dropped so an empty buffer never starts with 0.
  assign w_shift = w_capture && kp_if.entry_enable && !kp_if.clear &&
                   (r_count != 3'd4) &&
                   !((r_count == 3'd0) && (kp_if.digit == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_tens <= '0;
      r_min_ones <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
      r_count    <= '0;
      r_accepted <= 1'b0;
    end else begin
      r_accepted <= w_shift;
      if (kp_if.clear) begin
        r_min_tens <= '0;
        r_min_ones <= '0;
        r_sec_tens <= '0;
        r_sec_ones <= '0;
        r_count    <= '0;
      end else if (w_shift) begin
        r_min_tens <= r_min_ones;
        r_min_ones <= r_sec_tens;
        r_sec_tens <= r_sec_ones;
        r_sec_ones <= kp_if.digit;
        r_count    <= r_count + 3'd1;
      end
    end
  end

  assign kp_if.min_tens     = r_min_tens;
  assign kp_if.min_ones     = r_min_ones;
  assign kp_if.sec_tens     = r_sec_tens;
  assign kp_if.sec_ones     = r_sec_ones;
  assign kp_if.digit_count  = r_count;
  assign kp_if.entry_full   = (r_count == 3'd4);
  assign kp_if.time_valid   = (r_count != 3'd0);
  assign kp_if.key_accepted = r_accepted;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry: debounce latency, leading-zero and
// multi-key rejection, full buffer, enable/clear gating and mid-press reset.
module tb_keypad_time_entry;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  keypad_time_entry_if kp_if ();

  keypad_time_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp_if (kp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] buf_val();
    return {kp_if.min_tens, kp_if.min_ones, kp_if.sec_tens, kp_if.sec_ones};
  endfunction

  function automatic logic [9:0] key(input int k);
    logic [9:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Drives kp for n cycles from a negedge; records the cycle index of the
  // first key_accepted seen and the pulse count. Capture with 4-cycle debounce
  // shows up at index 5 (E0 is the first posedge after driving).
  task automatic hold(input logic [9:0] kp, input logic [3:0] dg, input int n,
                      output int first, output int np);
    kp_if.keypad = kp;
    kp_if.digit  = dg;
    first = -1;
    np    = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (kp_if.key_accepted) begin
        if (first < 0) first = i;
        np++;
      end
    end
  endtask

  task automatic press(input string tag, input int k, input logic [3:0] dg, input bit accept);
    int first, np;
    hold(key(k), dg, 6, first, np);
    check({tag, "_pulses"}, np, accept ? 1 : 0);
    if (accept) check({tag, "_latency"}, first, 5);
    hold('0, dg, 4, first, np);
    check({tag, "_release"}, np, 0);
  endtask

  task automatic do_clear();
    kp_if.clear = 1'b1;
    @(negedge clk);
    kp_if.clear = 1'b0;
  endtask

  initial begin
    int first, np;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    kp_if.keypad       = '0;
    kp_if.digit        = '0;
    kp_if.entry_enable = 1'b1;
    kp_if.clear        = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_buf",   buf_val(), 16'h0000);
    check("rst_count", kp_if.digit_count, 0);
    check("rst_full",  kp_if.entry_full, 0);
    check("rst_valid", kp_if.time_valid, 0);
    check("rst_acc",   kp_if.key_accepted, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Key 5 held 10 cycles: one pulse at E0+4, none while held.
    hold(key(5), 4'd5, 10, first, np);
    check("k5_latency", first, 5);
    check("k5_pulses",  np, 1);
    check("k5_buf",     buf_val(), 16'h0005);
    check("k5_count",   kp_if.digit_count, 1);
    check("k5_valid",   kp_if.time_valid, 1);
    hold('0, 4'd5, 4, first, np);
    check("k5_release", np, 0);

    do_clear();
    check("clr_buf",   buf_val(), 16'h0000);
    check("clr_count", kp_if.digit_count, 0);

    // 1,2,3,0 fills the buffer; a fifth key is dropped.
    press("d1", 1, 4'd1, 1'b1);
    press("d2", 2, 4'd2, 1'b1);
    press("d3", 3, 4'd3, 1'b1);
    check("d3_count", kp_if.digit_count, 3);
    check("d3_full",  kp_if.entry_full, 0);
    press("d0", 0, 4'd0, 1'b1);
    check("full_buf",   buf_val(), 16'h1230);
    check("full_count", kp_if.digit_count, 4);
    check("full_flag",  kp_if.entry_full, 1);
    press("d7_full", 7, 4'd7, 1'b0);
    check("d7_buf", buf_val(), 16'h1230);

    // Bounce: 3 for 2 cycles, 0 for 1, then steady 3.
    do_clear();
    hold(key(3), 4'd3, 2, first, np);
    check("bnc_a", np, 0);
    hold('0, 4'd3, 1, first, np);
    check("bnc_b", np, 0);
    hold(key(3), 4'd3, 10, first, np);
    check("bnc_latency", first, 5);
    check("bnc_pulses",  np, 1);
    check("bnc_buf",     buf_val(), 16'h0003);
    hold('0, 4'd3, 4, first, np);
    check("bnc_release", np, 0);

    // Leading zero and two keys together are both ignored.
    do_clear();
    press("lead0", 0, 4'd0, 1'b0);
    check("lead0_count", kp_if.digit_count, 0);
    hold(10'b1100000000, 4'd1, 6, first, np);
    check("multi_pulses", np, 0);
    check("multi_count",  kp_if.digit_count, 0);
    hold('0, 4'd1, 4, first, np);

    // Entry disabled: debounced but discarded.
    kp_if.entry_enable = 1'b0;
    press("dis9", 9, 4'd9, 1'b0);
    check("dis9_count", kp_if.digit_count, 0);
    kp_if.entry_enable = 1'b1;
    press("k7", 7, 4'd7, 1'b1);
    check("k7_buf", buf_val(), 16'h0007);

    // Clear lands exactly on the capture edge of key 4.
    kp_if.keypad = key(4);
    kp_if.digit  = 4'd4;
    repeat (4) @(negedge clk);
    kp_if.clear = 1'b1;
    @(negedge clk);
    kp_if.clear = 1'b0;
    check("clrcap_acc",   kp_if.key_accepted, 0);
    check("clrcap_buf",   buf_val(), 16'h0000);
    check("clrcap_count", kp_if.digit_count, 0);
    hold(key(4), 4'd4, 3, first, np);
    check("clrcap_hold", np, 0);
    hold('0, 4'd4, 4, first, np);
    check("clrcap_release", np, 0);

    // Reset in DEBOUNCE with 0042 loaded; held key re-debounced afterwards.
    press("r4", 4, 4'd4, 1'b1);
    press("r2", 2, 4'd2, 1'b1);
    check("pre_rst_buf", buf_val(), 16'h0042);
    kp_if.keypad = key(6);
    kp_if.digit  = 4'd6;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_buf",   buf_val(), 16'h0000);
    check("mid_rst_count", kp_if.digit_count, 0);
    check("mid_rst_valid", kp_if.time_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(key(6), 4'd6, 10, first, np);
    check("post_rst_latency", first, 5);
    check("post_rst_pulses",  np, 1);
    check("post_rst_buf",     buf_val(), 16'h0006);
    check("post_rst_count",   kp_if.digit_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
